// File: rtl/binning_pkg.sv
// Shared types and helpers for the KxK binning datapath: binning factor enum,
// accumulator sizing and saturation.
package binning_pkg;

  localparam int ACC_GUARD = 4;
  localparam int SAT_W     = 32;

  typedef enum logic {
    FAC_2X2 = 1'b0,
    FAC_4X4 = 1'b1
  } fac_t;

  function automatic int acc_w(input int pixel_w);
    return pixel_w + ACC_GUARD;
  endfunction

  // Right-shift that turns a KxK block total into its mean: log2(K*K).
  function automatic int unsigned fac_shift(input fac_t fac);
    return (fac == FAC_4X4) ? 32'd4 : 32'd2;
  endfunction

  function automatic logic [SAT_W-1:0] sat(input logic [SAT_W-1:0] acc,
                                           input int unsigned     width);
    logic [SAT_W-1:0] lim;
    lim = (SAT_W'(1) << width) - SAT_W'(1);
    return (acc > lim) ? lim : acc;
  endfunction

endpackage

// File: rtl/binning_line_ram.sv
// Simple dual-port line buffer: one write port, one registered read port.
// Holds the partial vertical sums of one line of horizontal groups.
module binning_line_ram
  import binning_pkg::*;
#(
  parameter int DEPTH  = 2048,
  parameter int WIDTH  = 12,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/binning_kxk.sv
// Run-time selectable 2x2 / 4x4 binning for multi-channel video, with bypass.
// Define BINNING_KXK_ROUND_EN to round averages half up instead of truncating.
module binning_kxk
  import binning_pkg::*;
#(
  parameter int LINE_SIZE_MAX = 4096,
  parameter int PIXEL_WIDTH   = 8,
  parameter int CH_COUNT      = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            bypass,
  input  logic                            fac_i,
  input  logic                            avg_i,
  input  logic [PIXEL_WIDTH*CH_COUNT-1:0] di_i,
  input  logic                            de_i,
  input  logic                            hs_i,
  input  logic                            vs_i,
  output logic [PIXEL_WIDTH*CH_COUNT-1:0] do_o,
  output logic                            de_o,
  output logic                            hs_o,
  output logic                            vs_o
);

  localparam int ACC_W  = acc_w(PIXEL_WIDTH);
  localparam int DEPTH  = LINE_SIZE_MAX / 2;
  localparam int GRP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW     = PIXEL_WIDTH * CH_COUNT;
  localparam int RAM_W  = CH_COUNT * ACC_W;

`ifdef BINNING_KXK_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  function automatic logic [PIXEL_WIDTH-1:0] norm(input logic [ACC_W-1:0] total,
                                                  input logic             avg,
                                                  input fac_t             fac);
    logic [SAT_W-1:0] w;
    int unsigned      sh;
    sh = fac_shift(fac);
    w  = SAT_W'(total);
    if (avg) begin
      if (ROUND_EN) w = w + (SAT_W'(1) << (sh - 32'd1));
      w = w >> sh;
    end
    return PIXEL_WIDTH'(sat(w, PIXEL_WIDTH));
  endfunction

  logic             vs_prev, hs_prev;
  logic             armed;
  fac_t             fac_q;
  logic             avg_q;
  logic [1:0]       col_mod;
  logic [GRP_W-1:0] grp;
  logic [1:0]       row;
  logic             line_has_de;

  logic             vs_rise, vs_fall, hs_rise;
  logic [1:0]       last_idx;
  logic             col_first, col_last, row_first, row_last;

  logic [CH_COUNT-1:0][ACC_W-1:0] hacc;
  logic [CH_COUNT-1:0][ACC_W-1:0] hsum;
  logic [CH_COUNT-1:0][ACC_W-1:0] tot;
  logic [CH_COUNT-1:0][ACC_W-1:0] rdata;

  logic                           ram_we, ram_re;

  logic                           vld_p0, de_p0, hs_p0, vs_p0, byp_p0;
  logic [CH_COUNT-1:0][ACC_W-1:0] tot_p0;
  logic [DW-1:0]                  di_p0;
  logic [DW-1:0]                  out_p0;

  assign vs_rise   = vs_i & ~vs_prev;
  assign vs_fall   = ~vs_i & vs_prev;
  assign hs_rise   = hs_i & ~hs_prev;
  assign last_idx  = (fac_q == FAC_4X4) ? 2'd3 : 2'd1;
  assign col_first = (col_mod == 2'd0);
  assign col_last  = (col_mod == last_idx);
  assign row_first = (row == 2'd0);
  assign row_last  = (row == last_idx);

  // Frame/line bookkeeping. vs_prev resets high so a reset inside an active
  // frame cannot be mistaken for a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev     <= 1'b1;
      hs_prev     <= 1'b1;
      armed       <= 1'b0;
      fac_q       <= FAC_2X2;
      avg_q       <= 1'b0;
      col_mod     <= 2'd0;
      grp         <= '0;
      row         <= 2'd0;
      line_has_de <= 1'b0;
    end else begin
      vs_prev <= vs_i;
      hs_prev <= hs_i;
      if (vs_rise) begin
        armed <= 1'b1;
        fac_q <= fac_t'(fac_i);
        avg_q <= avg_i;
      end
      if (hs_rise) begin
        col_mod     <= 2'd0;
        grp         <= '0;
        line_has_de <= 1'b0;
      end else if (de_i) begin
        line_has_de <= 1'b1;
        if (col_last) begin
          col_mod <= 2'd0;
          grp     <= grp + GRP_W'(1);
        end else begin
          col_mod <= col_mod + 2'd1;
        end
      end
      if (vs_fall) begin
        row <= 2'd0;
      end else if (hs_rise && line_has_de) begin
        row <= row_last ? 2'd0 : row + 2'd1;
      end
    end
  end

  always_comb begin
    hsum = '0;
    tot  = '0;
    for (int c = 0; c < CH_COUNT; c++) begin
      hsum[c] = (col_first ? '0 : hacc[c]) + ACC_W'(di_i[c*PIXEL_WIDTH +: PIXEL_WIDTH]);
      tot[c]  = hsum[c] + (row_first ? '0 : rdata[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hacc <= '0;
    else if (de_i) hacc <= hsum;
  end

  // Read the column partial at the group's first pixel so it is ready by its last.
  assign ram_re = de_i & col_first & ~row_first;
  assign ram_we = de_i & col_last & ~row_last;

  binning_line_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RAM_W),
    .ADDR_W(GRP_W)
  ) u_line_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(grp),
    .wdata(tot),
    .re   (ram_re),
    .raddr(grp),
    .rdata(rdata)
  );

  // Stage p0: block totals, bypass data and syncs captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      de_p0  <= 1'b0;
      hs_p0  <= 1'b1;
      vs_p0  <= 1'b0;
      byp_p0 <= 1'b0;
    end else begin
      vld_p0 <= armed & de_i & col_last & row_last;
      de_p0  <= de_i;
      hs_p0  <= hs_i;
      vs_p0  <= vs_i;
      byp_p0 <= bypass;
    end
  end

  always_ff @(posedge clk) begin
    tot_p0 <= tot;
    di_p0  <= di_i;
  end

  always_comb begin
    out_p0 = '0;
    for (int c = 0; c < CH_COUNT; c++) begin
      out_p0[c*PIXEL_WIDTH +: PIXEL_WIDTH] = norm(tot_p0[c], avg_q, fac_q);
    end
  end

  // Stage p1: normalised outputs; do_o holds between output pixels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_o <= '0;
      de_o <= 1'b0;
      hs_o <= 1'b1;
      vs_o <= 1'b0;
    end else begin
      hs_o <= hs_p0;
      vs_o <= vs_p0;
      if (byp_p0) begin
        do_o <= di_p0;
        de_o <= de_p0;
      end else begin
        de_o <= vld_p0;
        if (vld_p0) do_o <= out_p0;
      end
    end
  end

endmodule

// File: tb/tb_binning_kxk.sv
// Directed bench for binning_kxk: frames of known patterns, expected binned
// pixels queued with their due cycle and matched against the DUT output.
`timescale 1ns/1ps
module tb_binning_kxk;

  localparam int LSM = 64;
  localparam int PW  = 8;
  localparam int CH  = 3;
  localparam int DW  = PW * CH;

  logic          clk = 1'b0;
  logic          rst, bypass, fac_i, avg_i, de_i, hs_i, vs_i;
  logic [DW-1:0] di_i, do_o;
  logic          de_o, hs_o, vs_o;

  binning_kxk #(
    .LINE_SIZE_MAX(LSM),
    .PIXEL_WIDTH  (PW),
    .CH_COUNT     (CH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bypass(bypass),
    .fac_i (fac_i),
    .avg_i (avg_i),
    .di_i  (di_i),
    .de_i  (de_i),
    .hs_i  (hs_i),
    .vs_i  (vs_i),
    .do_o  (do_o),
    .de_o  (de_o),
    .hs_o  (hs_o),
    .vs_o  (vs_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc   = 0;
  logic          h1 = 1'b1, h2 = 1'b1, v1 = 1'b0, v2 = 1'b0;
  bit            sync_chk = 1'b0;
  bit            hold_chk = 1'b0;
  logic [DW-1:0] last_exp = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    h1  <= hs_i;
    h2  <= h1;
    v1  <= vs_i;
    v2  <= v1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pix(input int pat, input int x, input int y, input int ch);
    case (pat)
      0:       return PW'(x + 64 * ch);
      1:       return PW'(255);
      2:       return PW'(3);
      default: return PW'((x * 37 + y * 91 + ch * 53 + x * y * 5) & 255);
    endcase
  endfunction

  function automatic logic [DW-1:0] model(input int pat, input int x0, input int y0,
                                          input int f, input int avg);
    logic [DW-1:0] r;
    int            total;
    r = '0;
    for (int ch = 0; ch < CH; ch++) begin
      total = 0;
      for (int dy = 0; dy < f; dy++)
        for (int dx = 0; dx < f; dx++)
          total += int'(pix(pat, x0 + dx, y0 + dy, ch));
      if (avg != 0) begin
`ifdef BINNING_KXK_ROUND_EN
        total = (total + (f * f) / 2) / (f * f);
`else
        total = total / (f * f);
`endif
      end else if (total > (1 << PW) - 1) begin
        total = (1 << PW) - 1;
      end
      r[ch*PW +: PW] = PW'(total);
    end
    return r;
  endfunction

  task automatic run_frame(input int w, input int h, input int pat, input int fac,
                           input int avg, input int gap, input int byp,
                           input int rst_row, input int tog_row);
    int            f;
    bit            armed;
    logic [DW-1:0] pv;
    fac_i  = fac[0];
    avg_i  = avg[0];
    bypass = byp[0];
    repeat (3) step();
    vs_i  = 1'b1;
    f     = (fac != 0) ? 4 : 2;
    armed = 1'b1;
    repeat (3) step();
    for (int y = 0; y < h; y++) begin
      if (y == rst_row) begin
        sync_chk = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        assert ({do_o, de_o, hs_o, vs_o} === {{DW{1'b0}}, 1'b0, 1'b1, 1'b0}) else begin
          n_bad++;
          $error("FAIL midframe_reset: got do=%h de=%b hs=%b vs=%b want do=0 de=0 hs=1 vs=0",
                 do_o, de_o, hs_o, vs_o);
        end
        repeat (2) step();
        rst   = 1'b0;
        armed = 1'b0;
        repeat (3) step();
        sync_chk = 1'b1;
      end
      if (y == tog_row) begin
        fac_i = ~fac_i;
        avg_i = ~avg_i;
      end
      hs_i = 1'b0;
      step();
      for (int x = 0; x < w; x++) begin
        for (int ch = 0; ch < CH; ch++) pv[ch*PW +: PW] = pix(pat, x, y, ch);
        di_i = pv;
        de_i = 1'b1;
        if (byp != 0)
          sb.push_back('{pv, cyc + 2});
        else if (armed && (x % f == f - 1) && (y % f == f - 1))
          sb.push_back('{model(pat, x - f + 1, y - f + 1, f, avg), cyc + 2});
        step();
        de_i = 1'b0;
        repeat (gap) step();
      end
      hs_i = 1'b1;
      repeat (4) step();
    end
    vs_i = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    rst = 1'b1; bypass = 1'b0; fac_i = 1'b0; avg_i = 1'b1;
    de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b0; di_i = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst) last_exp = '0;
        if (sync_chk) begin
          n_cmp++;
          assert (hs_o === h2) else begin
            n_bad++; $error("FAIL hs_delay: got %b want %b at cyc %0d", hs_o, h2, cyc);
          end
          n_cmp++;
          assert (vs_o === v2) else begin
            n_bad++; $error("FAIL vs_delay: got %b want %b at cyc %0d", vs_o, v2, cyc);
          end
        end
        if (!rst && de_o === 1'b1) begin
          n_cmp++;
          assert (sb.size() != 0) else begin
            n_bad++; $error("FAIL unexpected_de_o: got de_o=1 (do=%h) want 0 at cyc %0d", do_o, cyc);
          end
          if (sb.size() != 0) begin
            e = sb.pop_front();
            n_cmp++;
            assert (do_o === e.data) else begin
              n_bad++; $error("FAIL pixel_data: got %h want %h at cyc %0d", do_o, e.data, cyc);
            end
            n_cmp++;
            assert (cyc === e.cyc) else begin
              n_bad++; $error("FAIL pixel_latency: got cyc %0d want cyc %0d", cyc, e.cyc);
            end
            last_exp = e.data;
          end
        end else if (!rst && hold_chk) begin
          n_cmp++;
          assert (do_o === last_exp) else begin
            n_bad++; $error("FAIL do_hold: got %h want %h at cyc %0d", do_o, last_exp, cyc);
          end
        end
      end
    join_none

    repeat (3) step();
    n_cmp++;
    assert (do_o === '0) else begin n_bad++; $error("FAIL reset_do: got %h want 0", do_o); end
    n_cmp++;
    assert (de_o === 1'b0) else begin n_bad++; $error("FAIL reset_de: got %b want 0", de_o); end
    n_cmp++;
    assert (hs_o === 1'b1) else begin n_bad++; $error("FAIL reset_hs: got %b want 1", hs_o); end
    n_cmp++;
    assert (vs_o === 1'b0) else begin n_bad++; $error("FAIL reset_vs: got %b want 0", vs_o); end
    rst = 1'b0;
    repeat (3) step();
    sync_chk = 1'b1;
    hold_chk = 1'b1;

    // w, h, pattern, 4x4, avg, gap, bypass, reset row, fac/avg toggle row
    run_frame(16, 16, 0, 0, 1, 0, 0, -1, -1);
    run_frame(16, 16, 0, 1, 1, 0, 0, -1, -1);
    run_frame(16, 16, 3, 0, 1, 0, 0, -1, -1);
    run_frame(16, 16, 3, 1, 1, 0, 0, -1, -1);
    run_frame(16, 16, 1, 0, 0, 0, 0, -1, -1);
    run_frame(16, 16, 2, 0, 0, 0, 0, -1, -1);
    run_frame(16, 16, 3, 1, 0, 0, 0, -1, -1);
    run_frame(16, 16, 0, 0, 1, 1, 0, -1, -1);
    run_frame(16, 16, 0, 0, 1, 3, 0, -1, -1);
    run_frame(15, 15, 3, 1, 1, 0, 0, -1, 6);
    run_frame(16, 16, 0, 0, 1, 0, 0, 5, -1);
    run_frame(16, 16, 0, 0, 1, 0, 0, -1, -1);
    hold_chk = 1'b0;
    run_frame(8, 4, 3, 0, 1, 0, 1, -1, -1);
    bypass = 1'b0;
    repeat (6) step();

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++; $error("FAIL missing_outputs: got %0d pending want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
